// File: rtl/pep_ks_cmd_gen_pkg.sv
// Shared definitions for the keyswitch command generator: default sizing,
// FSM state and launch-reason encodings, and a command-width helper.
package pep_ks_cmd_gen_pkg;

  localparam int TOTAL_PBS_NB_DFLT  = 32;
  localparam int BATCH_PBS_NB_DFLT  = 8;
  localparam int LWE_K_DFLT         = 6;
  localparam int TIMEOUT_CNT_W_DFLT = 32;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } ks_state_e;

  typedef enum logic [1:0] {
    LAUNCH_NONE,
    LAUNCH_FULL,
    LAUNCH_FLUSH,
    LAUNCH_TMO
  } launch_e;

  // Width of a packed command {ks_loop_c, ks_loop, wp, rp}. Each pointer
  // carries the pool index plus one wrap bit.
  function automatic int ks_cmd_w(input int total_pbs_nb, input int lwe_k);
    return 1 + $clog2(lwe_k + 1) + 2 * ($clog2(total_pbs_nb) + 1);
  endfunction

endpackage

// File: rtl/pep_ks_cmd_gen_if.sv
// Command channel from the generator to the keyswitch (valid/ready).
interface pep_ks_cmd_gen_if
  import pep_ks_cmd_gen_pkg::*;
#(
  parameter int KS_CMD_W = ks_cmd_w(TOTAL_PBS_NB_DFLT, LWE_K_DFLT)
);

  logic [KS_CMD_W-1:0] ks_cmd;
  logic                ks_cmd_vld;
  logic                ks_cmd_rdy;

  modport master (
    output ks_cmd,
    output ks_cmd_vld,
    input  ks_cmd_rdy
  );

  modport slave (
    input  ks_cmd,
    input  ks_cmd_vld,
    output ks_cmd_rdy
  );

endinterface

// File: rtl/pep_ks_cmd_gen_pool_pointer.sv
// Wrap-bit pool pointer. The MSB is the wrap bit, so a plain binary
// increment over the full width advances pt modulo the (power-of-two) pool
// size and toggles c on every wrap. A load takes priority over an increment.
module pep_pool_pointer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         a_rst_n,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] ptr
);

  // Pointer register: load, else increment, else hold.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      ptr <= '0;
    end else if (ld) begin
      ptr <= ld_val;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pep_ks_cmd_gen.sv
// Keyswitch command generator. Counts BLWE loads into a circular PBS pool,
// launches batches when full, on flush or on timeout, and issues one command
// per ks_loop column (0..LWE_K) of each batch to the keyswitch.
module pep_ks_cmd_gen
  import pep_ks_cmd_gen_pkg::*;
#(
  parameter  int TOTAL_PBS_NB  = TOTAL_PBS_NB_DFLT,
  parameter  int BATCH_PBS_NB  = BATCH_PBS_NB_DFLT,
  parameter  int LWE_K         = LWE_K_DFLT,
  parameter  int TIMEOUT_CNT_W = TIMEOUT_CNT_W_DFLT,
  localparam int PID_W         = $clog2(TOTAL_PBS_NB),
  localparam int LWE_K_P1_W    = $clog2(LWE_K + 1)
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic                     ldb_done,
  input  logic                     flush,
  input  logic [TIMEOUT_CNT_W-1:0] timeout_val,
  pep_ks_cmd_gen_if.master         ks_if,
  output logic                     batch_inc,
  output logic                     batch_flush_inc,
  output logic                     batch_timeout_inc,
  output logic                     error_ovf,
  output logic [PID_W:0]           info_wp,
  output logic [PID_W:0]           info_rp
);

  localparam int PTR_W = PID_W + 1;

  typedef struct packed {
    logic             c;
    logic [PID_W-1:0] pt;
  } pointer_t;

  typedef struct packed {
    logic                  ks_loop_c;
    logic [LWE_K_P1_W-1:0] ks_loop;
    pointer_t              wp;
    pointer_t              rp;
  } ks_cmd_t;

  localparam logic [PTR_W-1:0]      TOTAL_NB  = PTR_W'(TOTAL_PBS_NB);
  localparam logic [PTR_W-1:0]      BATCH_NB  = PTR_W'(BATCH_PBS_NB);
  localparam logic [LWE_K_P1_W-1:0] LAST_LOOP = LWE_K_P1_W'(LWE_K);

  // Occupancy between two wrap-bit pointers: 0..TOTAL_PBS_NB.
  function automatic logic [PTR_W-1:0] pt_elt_nb(input logic [PTR_W-1:0] w,
                                                 input logic [PTR_W-1:0] r);
    return w - r;
  endfunction

  ks_state_e                state, state_nxt;
  launch_e                  launch;
  logic [PTR_W-1:0]         wp, rp, bwp, bsize, elt_nb;
  logic [PTR_W-1:0]         launch_bwp, flush_base;
  logic [LWE_K_P1_W-1:0]    ks_loop;
  logic                     ks_loop_c;
  logic                     flush_pend, flush_set;
  logic [TIMEOUT_CNT_W-1:0] tmo_cnt;
  logic                     tmo_hit, launch_go;
  logic                     issue_acc, issue_last, wp_inc;
  ks_cmd_t                  cmd;

  assign elt_nb     = pt_elt_nb(wp, rp);
  assign tmo_hit    = (elt_nb != '0) && (tmo_cnt >= timeout_val);
  assign launch_go  = (launch != LAUNCH_NONE);
  assign launch_bwp = rp + bsize;
  assign issue_acc  = (state == ST_ISSUE) && ks_if.ks_cmd_rdy;
  assign issue_last = issue_acc && (ks_loop == LAST_LOOP);
  assign wp_inc     = ldb_done && (elt_nb != TOTAL_NB);

  // A flush is judged against the elements that will remain once the batch
  // in flight (or the one launching now) has been consumed.
  assign flush_base = (state == ST_ISSUE) ? bwp : (launch_go ? launch_bwp : rp);
  assign flush_set  = flush && ((pt_elt_nb(wp, flush_base) != '0) || ldb_done);

  pep_pool_pointer #(.W(PTR_W)) u_wp (
    .clk    (clk),
    .a_rst_n(a_rst_n),
    .inc    (wp_inc),
    .ld     (1'b0),
    .ld_val ('0),
    .ptr    (wp)
  );

  pep_pool_pointer #(.W(PTR_W)) u_rp (
    .clk    (clk),
    .a_rst_n(a_rst_n),
    .inc    (1'b0),
    .ld     (issue_last),
    .ld_val (bwp),
    .ptr    (rp)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Launch arbitration (full > flush > timeout) and next-state decode.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt         = state;
    launch            = LAUNCH_NONE;
    bsize             = '0;
    batch_inc         = 1'b0;
    batch_flush_inc   = 1'b0;
    batch_timeout_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elt_nb >= BATCH_NB) begin
          launch    = LAUNCH_FULL;
          bsize     = BATCH_NB;
          batch_inc = 1'b1;
        end else if (flush_pend && (elt_nb != '0)) begin
          launch          = LAUNCH_FLUSH;
          bsize           = elt_nb;
          batch_flush_inc = 1'b1;
        end else if (tmo_hit) begin
          launch            = LAUNCH_TMO;
          bsize             = elt_nb;
          batch_timeout_inc = 1'b1;
        end
        if (launch != LAUNCH_NONE) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Batch bookkeeping: batch end pointer, column counter, flush and timeout.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      bwp        <= '0;
      ks_loop    <= '0;
      ks_loop_c  <= 1'b0;
      flush_pend <= 1'b0;
      tmo_cnt    <= '0;
      error_ovf  <= 1'b0;
    end else begin
      if (launch_go) bwp <= launch_bwp;

      if (issue_last) begin
        ks_loop   <= '0;
        ks_loop_c <= ~ks_loop_c;
      end else if (issue_acc) begin
        ks_loop <= ks_loop + 1'b1;
      end

      if (flush_set) flush_pend <= 1'b1;
      else if (launch_go && (bsize == elt_nb)) flush_pend <= 1'b0;

      if ((elt_nb == '0) || launch_go) tmo_cnt <= '0;
      else if ((state == ST_IDLE) && (tmo_cnt != '1)) tmo_cnt <= tmo_cnt + 1'b1;

      error_ovf <= ldb_done && (elt_nb == TOTAL_NB);
    end
  end

  // Command output; held at zero when no command is offered.
  always_comb begin
    cmd.ks_loop_c = ks_loop_c;
    cmd.ks_loop   = ks_loop;
    cmd.wp        = bwp;
    cmd.rp        = rp;
  end

  assign ks_if.ks_cmd_vld = (state == ST_ISSUE);
  assign ks_if.ks_cmd     = (state == ST_ISSUE) ? cmd : '0;
  assign info_wp          = wp;
  assign info_rp          = rp;

endmodule

// File: tb/tb_pep_ks_cmd_gen.sv
// Directed bench for pep_ks_cmd_gen with an 8-entry pool, 4-PBS batches and
// LWE_K=3 (four columns per batch). Commands are 11 bits: {c, loop[1:0],
// wp[3:0], rp[3:0]}.
module tb_pep_ks_cmd_gen;

  localparam int CMD_W = 11;

  logic        clk = 1'b0;
  logic        a_rst_n = 1'b0;
  logic        ldb_done = 1'b0;
  logic        flush = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] timeout_val = 32'd1000;

  logic             batch_inc, batch_flush_inc, batch_timeout_inc, error_ovf;
  logic [3:0]       info_wp, info_rp;
  logic [CMD_W-1:0] cmd;
  logic             vld;

  pep_ks_cmd_gen_if #(.KS_CMD_W(CMD_W)) ks_if ();

  assign ks_if.ks_cmd_rdy = rdy;
  assign cmd              = ks_if.ks_cmd;
  assign vld              = ks_if.ks_cmd_vld;

  pep_ks_cmd_gen #(
    .TOTAL_PBS_NB (8),
    .BATCH_PBS_NB (4),
    .LWE_K        (3),
    .TIMEOUT_CNT_W(32)
  ) dut (
    .clk              (clk),
    .a_rst_n          (a_rst_n),
    .ldb_done         (ldb_done),
    .flush            (flush),
    .timeout_val      (timeout_val),
    .ks_if            (ks_if),
    .batch_inc        (batch_inc),
    .batch_flush_inc  (batch_flush_inc),
    .batch_timeout_inc(batch_timeout_inc),
    .error_ovf        (error_ovf),
    .info_wp          (info_wp),
    .info_rp          (info_rp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: collects accepted commands and counts pulses on the falling edge.
  logic [CMD_W-1:0] cmd_q[$];
  int n_full = 0, n_flush = 0, n_tmo = 0, n_ovf = 0;
  int cyc = 0, cyc_tmo = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (a_rst_n) begin
      if (vld && rdy) cmd_q.push_back(cmd);
      if (batch_inc) n_full++;
      if (batch_flush_inc) n_flush++;
      if (batch_timeout_inc) begin
        n_tmo++;
        cyc_tmo = cyc;
      end
      if (error_ovf) n_ovf++;
    end
  end

  function automatic logic [CMD_W-1:0] mk_cmd(input logic c, input logic [1:0] loop,
                                               input logic [3:0] wp, input logic [3:0] rp);
    return {c, loop, wp, rp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_rst_n  = 1'b0;
    ldb_done = 1'b0;
    flush    = 1'b0;
    rdy      = 1'b1;
    timeout_val = 32'd1000;
    repeat (2) tick();
    a_rst_n = 1'b1;
    tick();
    cmd_q.delete();
    n_full = 0; n_flush = 0; n_tmo = 0; n_ovf = 0;
  endtask

  task automatic load(input int n);
    ldb_done = 1'b1;
    repeat (n) tick();
    ldb_done = 1'b0;
  endtask

  task automatic wait_cmds(input string tag, input int n);
    int k = 0;
    while (cmd_q.size() < n && k < 50) begin
      tick();
      k++;
    end
    check({tag, " cmd count"}, cmd_q.size(), n);
  endtask

  task automatic check_batch(input string tag, input logic c, input logic [3:0] wp,
                             input logic [3:0] rp);
    for (int i = 0; i < 4; i++) begin
      if (cmd_q.size() > i)
        check($sformatf("%s cmd%0d", tag, i), cmd_q[i], mk_cmd(c, 2'(i), wp, rp));
    end
  endtask

  initial begin
    int lat;
    int k;

    // Reset state
    do_reset();
    check("rst vld", vld, 0);
    check("rst cmd", cmd, 0);
    check("rst info_wp", info_wp, 0);
    check("rst info_rp", info_rp, 0);
    check("rst error_ovf", error_ovf, 0);

    // 1: one full batch
    load(4);
    wait_cmds("t1", 4);
    check_batch("t1", 1'b0, 4'd4, 4'd0);
    repeat (2) tick();
    check("t1 info_rp", info_rp, 4);
    check("t1 vld idle", vld, 0);
    check("t1 batch_inc", n_full, 1);
    check("t1 no flush/tmo", n_flush + n_tmo, 0);

    // 2: partial batch on flush
    do_reset();
    load(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_cmds("t2", 4);
    check_batch("t2", 1'b0, 4'd2, 4'd0);
    check("t2 batch_flush_inc", n_flush, 1);
    check("t2 batch_inc", n_full, 0);
    tick();
    check("t2 info_rp", info_rp, 2);

    // 3: flush on empty pool is dropped, then a timeout batch
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    check("t3 nothing issued", cmd_q.size(), 0);
    timeout_val = 32'd10;
    load(1);
    lat = cyc;
    k = 0;
    while (n_tmo == 0 && k < 40) begin
      tick();
      k++;
    end
    check("t3 batch_timeout_inc", n_tmo, 1);
    lat = cyc_tmo - lat;
    check("t3 latency 9..12", (lat >= 9 && lat <= 12), 1);
    wait_cmds("t3", 4);
    check_batch("t3", 1'b0, 4'd1, 4'd0);
    check("t3 stale flush dropped", n_flush, 0);

    // 4: pool wrap over three batches
    do_reset();
    for (int b = 0; b < 3; b++) begin
      cmd_q.delete();
      load(4);
      wait_cmds($sformatf("t4 b%0d", b), 4);
      check_batch($sformatf("t4 b%0d", b), b[0], 4'(b * 4 + 4), 4'(b * 4));
      repeat (2) tick();
    end
    check("t4 info_rp", info_rp, 4'hC);
    check("t4 info_wp", info_wp, 4'hC);
    check("t4 batch_inc", n_full, 3);

    // 5: backpressure at column 2 with loads in flight
    do_reset();
    load(4);
    wait_cmds("t5 pre", 2);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ldb_done = (i < 2);
      @(negedge clk);
      check($sformatf("t5 hold%0d", i), cmd, mk_cmd(1'b0, 2'd2, 4'd4, 4'd0));
      tick();
    end
    ldb_done = 1'b0;
    check("t5 info_wp", info_wp, 6);
    rdy = 1'b1;
    wait_cmds("t5", 4);
    check_batch("t5", 1'b0, 4'd4, 4'd0);

    // 6: overflow on full pool, then reset mid-issue
    do_reset();
    rdy = 1'b0;
    load(8);
    check("t6 info_wp full", info_wp, 4'h8);
    check("t6 stalled vld", vld, 1);
    check("t6 stalled cmd", cmd, mk_cmd(1'b0, 2'd0, 4'd4, 4'd0));
    ldb_done = 1'b1;
    tick();
    ldb_done = 1'b0;
    @(negedge clk);
    check("t6 error_ovf", error_ovf, 1);
    check("t6 info_wp held", info_wp, 4'h8);
    tick();
    check("t6 error_ovf pulse", error_ovf, 0);
    check("t6 ovf count", n_ovf, 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("t6 rst vld", vld, 0);
    check("t6 rst info_wp", info_wp, 0);
    check("t6 rst info_rp", info_rp, 0);
    check("t6 rst cmd", cmd, 0);
    rdy = 1'b1;
    tick();
    a_rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pep_ks_cmd_gen.md
Name: pep_ks_cmd_gen

Overview:
- Keyswitch command generator in the PE-PBS sequencer, directly upstream of the keyswitch.
- Tracks BLWE-load completions in a circular PBS-location pool using wrap-bit pointers (pointer_t).
- Forms batches on full / flush / timeout conditions.
- Emits one ks_cmd_t per ks_loop column (0..LWE_K) of each batch over a valid/ready handshake.

Parameters:
- TOTAL_PBS_NB, 32, PBS locations in pool; power of 2.
- BATCH_PBS_NB, 8, max PBS per batch; divides TOTAL_PBS_NB.
- LWE_K, 6, LWE mask size; columns per batch = LWE_K+1.
- TIMEOUT_CNT_W, 32, timeout counter width.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- ldb_done  in  1  one BLWE loaded into pool location wp.pt; 1-cycle pulse
- flush  in  1  request to issue a partial batch; pulse
- timeout_val  in  TIMEOUT_CNT_W  partial-batch timeout in cycles; quasi-static
- ks_cmd  out  KS_CMD_W  ks_cmd_t {ks_loop_c, ks_loop, wp, rp}
- ks_cmd_vld  out  1  command valid
- ks_cmd_rdy  in  1  keyswitch accepts command
- batch_inc  out  1  pulse when a full batch starts issuing
- batch_flush_inc  out  1  pulse when a flush-triggered batch starts issuing
- batch_timeout_inc  out  1  pulse when a timeout-triggered batch starts issuing
- error_ovf  out  1  pulse: ldb_done while pool full
- info_wp  out  PID_W+1  current write pointer
- info_rp  out  PID_W+1  current read pointer

Behaviour:
- Reset state: wp=rp=0 (c=0, pt=0), state IDLE, ks_loop=0, ks_loop_c=0, flush_pend=0, tmo_cnt=0. All outputs 0.
- Pointers: increment pt mod TOTAL_PBS_NB; toggle c on wrap 31->0. elt_nb = pt_elt_nb(wp,rp), range 0..TOTAL_PBS_NB.
- ldb_done:
  - elt_nb<TOTAL_PBS_NB: wp advances next cycle.
  - elt_nb==TOTAL_PBS_NB: wp unchanged; error_ovf=1 the next cycle.
- flush:
  - Sets flush_pend if elt_nb>0, or if ldb_done is asserted in the same cycle.
  - Otherwise dropped.
- tmo_cnt:
  - Cleared while elt_nb==0, and in the cycle a batch is launched.
  - Otherwise increments in IDLE, saturating.
  - Timeout fires when elt_nb>0 && tmo_cnt>=timeout_val; timeout_val=0 means issue immediately.
- State IDLE, launch priority (registered elt_nb):
  1. elt_nb>=BATCH_PBS_NB -> bsize=BATCH_PBS_NB, batch_inc.
  2. flush_pend -> bsize=elt_nb, batch_flush_inc.
  3. timeout -> bsize=elt_nb, batch_timeout_inc.
- On launch:
  - Latch bwp = rp+bsize.
  - Clear flush_pend if bsize==elt_nb.
  - Go to ISSUE; exactly one inc pulse that cycle.
- State ISSUE:
  - ks_cmd_vld=1, ks_cmd={ks_loop_c, ks_loop, bwp, rp}.
  - Command fields are stable while vld && !rdy.
  - On vld&&rdy with ks_loop<LWE_K: ks_loop+1.
  - On vld&&rdy with ks_loop==LWE_K:
    - ks_loop=0, ks_loop_c toggles, rp=bwp, return to IDLE.
    - Next launch no earlier than the following cycle.
- Loads during ISSUE continue to advance wp. Flush during ISSUE is recorded against the remaining elements, evaluated with elt_nb after the rp update.
- Asynchronous reset mid-ISSUE: everything returns to reset values immediately; partial column sequence is abandoned.
- Widths: ks_loop LWE_K_P1_W bits; pointer arithmetic in PID_W+1 bits; no saturation on pt.

Decomposition:
- Shared package (pep_common_param_pkg): pointer_t, ks_cmd_t, KS_CMD_W, PID_W, PID_WW, LWE_K_P1_W, TIMEOUT_CNT_W, pt_elt_nb.
- One natural sub-module: pep_pool_pointer — wrap-bit pointer register with increment-by-1 / load-value ports. Instantiated for wp and rp.

Test Plan (TOTAL_PBS_NB=8, BATCH_PBS_NB=4, LWE_K=3, rdy=1 unless stated):
1. 4 ldb_done pulses -> batch_inc once; 4 cmds ks_loop 0,1,2,3 with rp=0, wp=4, ks_loop_c=0; then info_rp=4.
2. 2 ldb_done + flush -> batch_flush_inc; 4 cmds with rp=0, wp=2.
3. flush with elt_nb=0 -> nothing issued; then 1 ldb_done, timeout_val=10 -> batch_timeout_inc about 10 cycles later, wp=1.
4. Pool wrap: 3 full batches (12 loads) -> third batch rp={1,0}, wp={1,4}; ks_loop_c toggles per batch: 0,1,0.
5. Backpressure: rdy low for 5 cycles at ks_loop=2 -> ks_cmd held constant; concurrent ldb_done still advances info_wp.
6. 8 loads with rdy=0, then a 9th ldb_done -> error_ovf pulse, info_wp unchanged; reset asserted mid-ISSUE -> vld=0, pointers {0,0} immediately.
